layer_compositor: RTL and testbench

- Parametrised successor to the fixed 6-input max/colour stage of the display top.
- Merges NLAYERS per-pixel colour codes from text/dict display layers into one RGB pixel.
- Supports two arbitration modes, a runtime-writable palette, per-layer enable and per-layer blink.
- Sits between the display layers and the VGA pins; delays hsync/vsync/valid to stay aligned with the pixel data.

---
 rtl/layer_compositor_pkg.sv | 31 +++
 rtl/layer_compositor_if.sv | 27 ++
 rtl/layer_compositor_code_arbiter.sv | 60 ++++++
 rtl/layer_compositor.sv | 116 +++++++++++
 tb/tb_layer_compositor.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/layer_compositor_pkg.sv
// Shared display definitions: default widths, colour constants, arbitration
// mode encodings and the reset-time palette contents.
package display_pkg;

  localparam int DEF_CODE_W  = 3;
  localparam int DEF_COLOR_W = 12;

  localparam logic [11:0] WHITE = 12'hFFF;
  localparam logic [11:0] CYAN  = 12'h0FF;
  localparam logic [11:0] RED   = 12'hF00;
  localparam logic [11:0] GREEN = 12'h0F0;
  localparam logic [11:0] BLACK = 12'h000;
  localparam logic [11:0] ERR   = 12'h00F;

  localparam logic MODE_MAX   = 1'b0;
  localparam logic MODE_FIRST = 1'b1;

  function automatic logic [11:0] default_palette(input int unsigned idx);
    logic [11:0] col_s;
    case (idx)
      32'd0:   col_s = WHITE;
      32'd1:   col_s = CYAN;
      32'd2:   col_s = RED;
      32'd3:   col_s = GREEN;
      32'd4:   col_s = BLACK;
      default: col_s = ERR;
    endcase
    return col_s;
  endfunction

endpackage

// File: rtl/layer_compositor_if.sv
// Pixel stream into and out of the compositor: strobe, layer codes, syncs
// and the resulting RGB pixel.
interface layer_compositor_if #(
  parameter int NLAYERS = 8,
  parameter int CODE_W  = 3,
  parameter int COLOR_W = 12
);
  logic                      pix_en;
  logic [NLAYERS*CODE_W-1:0] codes;
  logic                      hsync_in;
  logic                      vsync_in;
  logic                      valid_in;
  logic [COLOR_W-1:0]        rgb;
  logic                      hsync;
  logic                      vsync;
  logic                      valid;

  modport master (
    output pix_en, codes, hsync_in, vsync_in, valid_in,
    input  rgb, hsync, vsync, valid
  );

  modport slave (
    input  pix_en, codes, hsync_in, vsync_in, valid_in,
    output rgb, hsync, vsync, valid
  );
endinterface

// File: rtl/layer_compositor_code_arbiter.sv
// Combinational layer arbitration: balanced max tree for max-code mode and a
// priority encoder for lowest-index-non-zero mode.
module code_arbiter
  import display_pkg::*;
#(
  parameter int NLAYERS = 8,
  parameter int CODE_W  = DEF_CODE_W
) (
  input  logic [NLAYERS*CODE_W-1:0] codes,
  input  logic                      mode,
  output logic [CODE_W-1:0]         code
);

  localparam int LEVELS = $clog2(NLAYERS);
  localparam int NPAD   = 1 << LEVELS;

  logic [CODE_W-1:0] max_s;
  logic [CODE_W-1:0] first_s;

  function automatic logic [CODE_W-1:0] max_code(input logic [CODE_W-1:0] a,
                                                 input logic [CODE_W-1:0] b);
    return (a >= b) ? a : b;
  endfunction

  // Leaves padded with code 0 up to a power of two; each level halves the node count.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    logic [CODE_W-1:0] node_s [NPAD >> l];
    for (genvar j = 0; j < (NPAD >> l); j++) begin : g_node
      if (l == 0) begin : g_leaf
        if (j < NLAYERS) begin : g_in
          assign node_s[j] = codes[j*CODE_W +: CODE_W];
        end else begin : g_pad
          assign node_s[j] = {CODE_W{1'b0}};
        end
      end else begin : g_max
        assign node_s[j] = max_code(g_lvl[l-1].node_s[2*j], g_lvl[l-1].node_s[2*j+1]);
      end
    end
  end

  assign max_s = g_lvl[LEVELS].node_s[0];

  // Priority encoder: scanning downward leaves the lowest-index non-zero code.
  always_comb begin
    first_s = {CODE_W{1'b0}};
    for (int i = NLAYERS - 1; i >= 0; i--) begin
      first_s = (codes[i*CODE_W +: CODE_W] != {CODE_W{1'b0}}) ? codes[i*CODE_W +: CODE_W] : first_s;
    end
  end

  // Mode select between the two arbitration results.
  always_comb begin
    case (mode)
      MODE_FIRST: code = first_s;
      MODE_MAX:   code = max_s;
      default:    code = max_s;
    endcase
  end

endmodule

// File: rtl/layer_compositor.sv
// Three-stage pix_en-qualified compositor: layer masking, arbitration and
// palette lookup, with syncs delayed to match and a frame-based blink phase.
module layer_compositor
  import display_pkg::*;
#(
  parameter int NLAYERS      = 8,
  parameter int CODE_W       = DEF_CODE_W,
  parameter int COLOR_W      = DEF_COLOR_W,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                clk,
  input  logic                rst,
  layer_compositor_if.slave   px,
  input  logic [NLAYERS-1:0]  layer_en,
  input  logic [NLAYERS-1:0]  blink_mask,
  input  logic                mode,
  input  logic                pal_we,
  input  logic [CODE_W-1:0]   pal_addr,
  input  logic [COLOR_W-1:0]  pal_data,
  output logic                blink_phase
);

  localparam int         PAL_N      = 1 << CODE_W;
  localparam logic [7:0] FRAME_LAST = 8'(BLINK_FRAMES - 1);

  logic [NLAYERS*CODE_W-1:0] masked_s;
  logic [NLAYERS*CODE_W-1:0] codes_s1_r;
  logic                      mode_s1_r;
  logic [CODE_W-1:0]         arb_code_s;
  logic [CODE_W-1:0]         code_s2_r;
  logic [2:0]                hs_r;
  logic [2:0]                vs_r;
  logic [2:0]                vld_r;
  logic [COLOR_W-1:0]        rgb_r;
  logic [COLOR_W-1:0]        pal_r [PAL_N];
  logic [7:0]                frame_cnt_r;
  logic                      blink_phase_r;
  logic                      vsync_rise_s;

  // Layer masking uses the phase in force when the pixel enters S1.
  always_comb begin
    masked_s = {(NLAYERS*CODE_W){1'b0}};
    for (int i = 0; i < NLAYERS; i++) begin
      if (!layer_en[i] || (blink_mask[i] && blink_phase_r)) begin
        masked_s[i*CODE_W +: CODE_W] = {CODE_W{1'b0}};
      end else begin
        masked_s[i*CODE_W +: CODE_W] = px.codes[i*CODE_W +: CODE_W];
      end
    end
  end

  code_arbiter #(
    .NLAYERS (NLAYERS),
    .CODE_W  (CODE_W)
  ) u_code_arbiter (
    .codes (codes_s1_r),
    .mode  (mode_s1_r),
    .code  (arb_code_s)
  );

  // Pixel pipeline S1..S3; syncs and valid ride in 3-deep shift registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      codes_s1_r <= {(NLAYERS*CODE_W){1'b0}};
      mode_s1_r  <= 1'b0;
      code_s2_r  <= {CODE_W{1'b0}};
      hs_r       <= 3'b000;
      vs_r       <= 3'b000;
      vld_r      <= 3'b000;
      rgb_r      <= {COLOR_W{1'b0}};
    end else if (px.pix_en) begin
      codes_s1_r <= masked_s;
      mode_s1_r  <= mode;
      code_s2_r  <= arb_code_s;
      hs_r       <= {hs_r[1:0], px.hsync_in};
      vs_r       <= {vs_r[1:0], px.vsync_in};
      vld_r      <= {vld_r[1:0], px.valid_in};
      rgb_r      <= vld_r[1] ? pal_r[code_s2_r] : {COLOR_W{1'b0}};
    end
  end

  // Palette storage; a same-edge lookup sees the old colour.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PAL_N; i++) begin
        pal_r[i] <= COLOR_W'(default_palette(i));
      end
    end else if (pal_we) begin
      pal_r[pal_addr] <= pal_data;
    end
  end

  assign vsync_rise_s = px.pix_en && px.vsync_in && !vs_r[0];

  // Frame counter and blink phase, advanced only at a vsync rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_r   <= 8'd0;
      blink_phase_r <= 1'b0;
    end else if (vsync_rise_s) begin
      if (frame_cnt_r == FRAME_LAST) begin
        frame_cnt_r   <= 8'd0;
        blink_phase_r <= ~blink_phase_r;
      end else begin
        frame_cnt_r <= frame_cnt_r + 8'd1;
      end
    end
  end

  assign px.rgb      = rgb_r;
  assign px.hsync    = hs_r[2];
  assign px.vsync    = vs_r[2];
  assign px.valid    = vld_r[2];
  assign blink_phase = blink_phase_r;

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor: vector table plus hand-written
// palette, blink and async-reset sequences, all backed by a scoreboard.
module tb_layer_compositor;

  localparam int NL = 8;
  localparam int CW = 3;
  localparam int KW = 12;
  localparam int BF = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  layer_compositor_if #(.NLAYERS(NL), .CODE_W(CW), .COLOR_W(KW)) px ();

  logic [NL-1:0] layer_en;
  logic [NL-1:0] blink_mask;
  logic          mode;
  logic          pal_we;
  logic [CW-1:0] pal_addr;
  logic [KW-1:0] pal_data;
  logic          blink_phase;

  layer_compositor #(
    .NLAYERS(NL), .CODE_W(CW), .COLOR_W(KW), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst(rst), .px(px),
    .layer_en(layer_en), .blink_mask(blink_mask), .mode(mode),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .blink_phase(blink_phase)
  );

  typedef struct {
    logic [CW-1:0] code;
    logic          hs;
    logic          vs;
    logic          vld;
  } exp_t;

  typedef struct {
    logic [NL*CW-1:0] codes;
    logic [NL-1:0]    en;
    logic             md;
    logic [KW-1:0]    rgb;
  } vec_t;

  exp_t          q[$];
  logic [KW-1:0] mpal [8];
  logic          m_phase;
  logic          m_vs1;
  logic [7:0]    m_cnt;
  int            n_cmp = 0;
  int            n_bad = 0;
  vec_t          vt [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_t z;
    mpal[0] = 12'hFFF; mpal[1] = 12'h0FF; mpal[2] = 12'hF00; mpal[3] = 12'h0F0;
    mpal[4] = 12'h000; mpal[5] = 12'h00F; mpal[6] = 12'h00F; mpal[7] = 12'h00F;
    m_phase = 1'b0;
    m_vs1   = 1'b0;
    m_cnt   = 8'd0;
    z.code = 3'd0; z.hs = 1'b0; z.vs = 1'b0; z.vld = 1'b0;
    q.delete();
    q.push_back(z);
    q.push_back(z);
  endtask

  function automatic logic [CW-1:0] m_arb();
    logic [CW-1:0] c;
    logic [CW-1:0] best  = 3'd0;
    logic [CW-1:0] first = 3'd0;
    bit            found = 1'b0;
    for (int i = 0; i < NL; i++) begin
      c = px.codes[i*CW +: CW];
      if (!layer_en[i] || (blink_mask[i] && m_phase)) c = 3'd0;
      if (c > best) best = c;
      if (!found && c != 3'd0) begin
        first = c;
        found = 1'b1;
      end
    end
    return mode ? first : best;
  endfunction

  // One pix_en strobe followed by three idle clocks; checks the oldest queued pixel.
  task automatic strobe();
    exp_t          o;
    exp_t          e;
    logic [KW-1:0] want;
    o    = q.pop_front();
    want = o.vld ? mpal[o.code] : 12'h000;
    e.code = m_arb();
    e.hs   = px.hsync_in;
    e.vs   = px.vsync_in;
    e.vld  = px.valid_in;
    q.push_back(e);
    if (px.vsync_in && !m_vs1) begin
      if (m_cnt == 8'(BF - 1)) begin
        m_cnt   = 8'd0;
        m_phase = ~m_phase;
      end else begin
        m_cnt = m_cnt + 8'd1;
      end
    end
    m_vs1 = px.vsync_in;
    px.pix_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    px.pix_en = 1'b0;
    if (pal_we) begin
      mpal[pal_addr] = pal_data;
      pal_we = 1'b0;
    end
    chk("rgb", 32'(px.rgb), 32'(want));
    chk("hsync", 32'(px.hsync), 32'(o.hs));
    chk("vsync", 32'(px.vsync), 32'(o.vs));
    chk("valid", 32'(px.valid), 32'(o.vld));
    chk("blink_phase", 32'(blink_phase), 32'(m_phase));
    repeat (3) @(negedge clk);
  endtask

  task automatic pal_write_idle(input logic [CW-1:0] a, input logic [KW-1:0] d);
    pal_addr = a;
    pal_data = d;
    pal_we   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pal_we  = 1'b0;
    mpal[a] = d;
  endtask

  initial begin
    rst = 1'b0;
    px.pix_en = 1'b0; px.codes = 24'h0; px.hsync_in = 1'b0; px.vsync_in = 1'b0;
    px.valid_in = 1'b1;
    layer_en = 8'hFF; blink_mask = 8'h00; mode = 1'b0;
    pal_we = 1'b0; pal_addr = 3'd0; pal_data = 12'h000;
    model_reset();

    vt[0] = '{24'h0, 8'hFF, 1'b0, 12'hFFF};
    vt[1] = '{{3'd0,3'd0,3'd2,3'd0,3'd3,3'd0,3'd0,3'd1}, 8'hFF, 1'b0, 12'h0F0};
    vt[2] = '{{3'd0,3'd0,3'd2,3'd0,3'd3,3'd0,3'd0,3'd1}, 8'hF7, 1'b0, 12'hF00};
    vt[3] = '{{3'd0,3'd0,3'd2,3'd0,3'd3,3'd0,3'd0,3'd1}, 8'hFF, 1'b1, 12'h0FF};
    vt[4] = '{{3'd0,3'd0,3'd2,3'd0,3'd3,3'd0,3'd0,3'd0}, 8'hFF, 1'b1, 12'h0F0};
    vt[5] = '{{3'd7,3'd0,3'd0,3'd0,3'd0,3'd0,3'd4,3'd0}, 8'hFF, 1'b0, 12'h00F};
    vt[6] = '{{3'd7,3'd0,3'd0,3'd0,3'd0,3'd0,3'd4,3'd0}, 8'hFF, 1'b1, 12'h000};
    vt[7] = '{{3'd7,3'd0,3'd0,3'd0,3'd0,3'd0,3'd4,3'd0}, 8'h00, 1'b0, 12'hFFF};
    vt[8] = '{{3'd0,3'd2,3'd0,3'd0,3'd0,3'd1,3'd0,3'd0}, 8'hFF, 1'b1, 12'h0FF};

    repeat (3) @(negedge clk);
    chk("reset_rgb", 32'(px.rgb), 32'h0);
    chk("reset_valid", 32'(px.valid), 32'h0);
    chk("reset_hsync", 32'(px.hsync), 32'h0);
    chk("reset_blink", 32'(blink_phase), 32'h0);
    rst = 1'b1;

    for (int k = 0; k < 3; k++) begin
      px.hsync_in = k[0];
      strobe();
    end
    chk("reset_to_white", 32'(px.rgb), 32'hFFF);

    for (int i = 0; i < 9; i++) begin
      px.codes = vt[i].codes;
      layer_en = vt[i].en;
      mode     = vt[i].md;
      for (int k = 0; k < 3; k++) begin
        px.hsync_in = ~px.hsync_in;
        strobe();
      end
      chk($sformatf("vec%0d", i), 32'(px.rgb), 32'(vt[i].rgb));
    end

    // Palette: same-edge lookup keeps the old colour, idle-cycle writes still land.
    px.codes = {3'd0,3'd0,3'd2,3'd0,3'd0,3'd0,3'd0,3'd0};
    layer_en = 8'hFF; mode = 1'b0;
    repeat (3) strobe();
    chk("pal_before", 32'(px.rgb), 32'hF00);
    pal_addr = 3'd2; pal_data = 12'hABC; pal_we = 1'b1;
    strobe();
    chk("pal_same_cycle", 32'(px.rgb), 32'hF00);
    strobe();
    chk("pal_new", 32'(px.rgb), 32'hABC);
    pal_write_idle(3'd2, 12'h123);
    strobe();
    chk("pal_idle_write", 32'(px.rgb), 32'h123);

    // Blink: layer 3 masked every other pair of frames.
    px.codes = {3'd0,3'd0,3'd0,3'd0,3'd3,3'd0,3'd0,3'd0};
    blink_mask = 8'h08;
    for (int f = 0; f < 6; f++) begin
      px.vsync_in = 1'b1;
      strobe();
      chk("blink_hand", 32'(blink_phase), 32'(((f + 1) / 2) % 2));
      strobe();
      px.vsync_in = 1'b0;
      repeat (3) strobe();
      chk("blink_rgb", 32'(px.rgb), (((f + 1) / 2) % 2 == 1) ? 32'hFFF : 32'h0F0);
    end

    // Async reset between clock edges.
    blink_mask = 8'h00;
    px.codes = {3'd0,3'd0,3'd2,3'd0,3'd0,3'd0,3'd0,3'd0};
    repeat (3) strobe();
    #2 rst = 1'b0;
    #1;
    chk("async_rgb", 32'(px.rgb), 32'h0);
    chk("async_valid", 32'(px.valid), 32'h0);
    chk("async_blink", 32'(blink_phase), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (3) strobe();
    chk("reset_default_pal", 32'(px.rgb), 32'hF00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
